shared_port_arbiter: RTL and testbench

//   Gives one shared output port to one of N requesters at a time, so the port always has exactly one driver.

---
 rtl/shared_port_arbiter.sv | 97 +++++++++
 tb/tb_shared_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter: round-robin owner of one valid/ready port, held for a whole burst until last.
// Define SHARED_PORT_ARB_TIMEOUT_EN to force a release (and pulse err_o) after TIMEOUT stalled cycles.
module shared_port_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N-1:0]                         req_i,
    input  logic [N-1:0]                         last_i,
    input  logic [N*W-1:0]                       data_i,
    output logic [N-1:0]                         ready_o,
    output logic [N-1:0]                         grant_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner_o,
    output logic                                 out_valid_o,
    output logic [W-1:0]                         out_data_o,
    input  logic                                 out_ready_i,
    output logic                                 err_o
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d, ptr_q, ptr_d, nxt_ptr;
    logic [N-1:0]   own_oh, mask;
    logic [IDW:0]   pick_idle, pick_rel;
    logic           busy, beat, rel, fire;

    // Returns {found, index} of the first set bit scanning upward from p with wrap.
    function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW:0] res;
        int           k;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(p) + i) % N;
            if (r[k]) res = {1'b1, IDW'(k)};
        end
        return res;
    endfunction

    assign busy        = (state_q == BUSY);
    assign own_oh      = N'(1) << owner_q;
    assign grant_o     = busy ? own_oh : '0;
    assign owner_o     = owner_q;
    assign out_valid_o = busy & req_i[owner_q];
    assign out_data_o  = busy ? data_i[owner_q*W +: W] : '0;
    assign ready_o     = (busy & out_ready_i) ? own_oh : '0;
    assign beat        = out_valid_o & out_ready_i;
    assign rel         = beat & last_i[owner_q];
    assign nxt_ptr     = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
    assign mask        = (N == 1) ? req_i : (req_i & ~own_oh);
    assign pick_idle   = pick(req_i, ptr_q);
    assign pick_rel    = pick(mask, nxt_ptr);

`ifdef SHARED_PORT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign fire  = busy & ~beat & (cnt_q == CW'(TIMEOUT));
    assign cnt_d = (!busy || beat || fire) ? '0 : cnt_q + 1'b1;
    assign err_o = fire;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign fire  = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (!busy) begin
            state_d = pick_idle[IDW] ? BUSY : IDLE;
            owner_d = pick_idle[IDW] ? pick_idle[IDW-1:0] : owner_q;
        end else if (rel || fire) begin
            ptr_d   = nxt_ptr;
            state_d = pick_rel[IDW] ? BUSY : IDLE;
            owner_d = pick_rel[IDW] ? pick_rel[IDW-1:0] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb_shared_port_arbiter: directed scenarios plus a randomized run against a burst-level reference model.
module tb_shared_port_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, last, ready, grant;
    logic [N*W-1:0] data;
    logic [1:0]   owner;
    logic         out_valid, out_ready, err;
    logic [W-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    int m_owner, m_ptr, m_stall;

    shared_port_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req), .last_i(last), .data_i(data),
        .ready_o(ready), .grant_o(grant), .owner_o(owner), .out_valid_o(out_valid),
        .out_data_o(out_data), .out_ready_i(out_ready), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; last = '0; out_ready = 1'b0; data = '0;
        cyc();
        rst = 1'b0;
    endtask

    function automatic int scan(logic [N-1:0] r, int p, int excl);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (p + i) % N;
            if (k != excl && r[k]) return k;
        end
        return -1;
    endfunction

    task automatic test_reset;
        do_reset();
        req = 4'b0101; data = 32'hDEADBEEF; out_ready = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin failures++; $display("FAIL reset_port got=%b/%h exp=0/00", out_valid, out_data); end
        checks++; if (ready !== 4'b0000 || err !== 1'b0) begin failures++; $display("FAIL reset_ready_err got=%b/%b exp=0000/0", ready, err); end
    endtask

    task automatic test_burst;
        do_reset();
        req = 4'b0101; last = 4'b0000; out_ready = 1'b1; data = 32'h44332211;
        cyc();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL burst_grant1 got=%b exp=0001", grant); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || ready !== 4'b0001) begin failures++; $display("FAIL burst_port got=%b/%h/%b exp=1/11/0001", out_valid, out_data, ready); end
        cyc();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL burst_hold got=%b exp=0001", grant); end
        cyc();
        last = 4'b0001;
        cyc();
        checks++; if (grant !== 4'b0100 || owner !== 2'd2) begin failures++; $display("FAIL burst_next got=%b/%0d exp=0100/2", grant, owner); end
    endtask

    task automatic test_round_robin;
        do_reset();
        req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (grant !== 4'(1 << (i % N))) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, grant, 4'(1 << (i % N))); end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        req = 4'b0100; last = 4'b0000; out_ready = 1'b0; data = 32'h33A51100;
        cyc();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_data !== 8'hA5 || ready !== 4'b0000 || grant !== 4'b0100 || out_valid !== 1'b1) begin
                failures++; $display("FAIL bp_stall%0d got=%h/%b/%b exp=a5/0000/0100", i, out_data, ready, grant);
            end
            cyc();
        end
        out_ready = 1'b1; last = 4'b0100;
        #1;
        checks++; if (ready !== 4'b0100) begin failures++; $display("FAIL bp_ready got=%b exp=0100", ready); end
        cyc();
        out_ready = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_single_beat got=%b/%b exp=0000/0", grant, out_valid); end
    endtask

    task automatic test_mid_reset;
        do_reset();
        req = 4'b0010; last = 4'b0000; out_ready = 1'b1; data = 32'h00007700;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b/%b exp=0000/0", grant, out_valid); end
        req = 4'b1111;
        cyc();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL midrst_regrant got=%b exp=0001", grant); end
    endtask

    task automatic test_wrap;
        do_reset();
        req = 4'b1000; last = 4'b1000; out_ready = 1'b1;
        cyc();
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL wrap_owner3 got=%b exp=1000", grant); end
        req = 4'b1001;
        cyc();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL wrap_next got=%b exp=0001", grant); end
    endtask

    task automatic test_timeout;
        do_reset();
        req = 4'b1000; last = 4'b0000; out_ready = 1'b1;
        cyc();
        req = 4'b0000;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            #1;
            checks++; if (err !== 1'b0 || grant !== 4'b1000) begin failures++; $display("FAIL to_stall%0d got=%b/%b exp=0/1000", i, err, grant); end
            cyc();
        end
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err); end
        cyc();
        checks++; if (err !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL to_release got=%b/%b exp=0/0000", err, grant); end
`else
        for (int i = 0; i < 100; i++) begin
            #1;
            checks++; if (err !== 1'b0 || grant !== 4'b1000) begin failures++; $display("FAIL hold%0d got=%b/%b exp=0/1000", i, err, grant); end
            cyc();
        end
`endif
    endtask

    task automatic test_random;
        logic [N-1:0] eg, er;
        logic         ev, eb, ee;
        logic [W-1:0] ed;
        do_reset();
        m_owner = -1; m_ptr = 0; m_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req       = 4'($urandom_range(0, 15));
            last      = 4'($urandom & $urandom);
            data      = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            ev = (m_owner >= 0) && req[m_owner];
            ed = (m_owner >= 0) ? data[m_owner*W +: W] : 8'h00;
            er = (m_owner >= 0 && out_ready) ? eg : 4'b0000;
            eb = ev && out_ready;
`ifdef SHARED_PORT_ARB_TIMEOUT_EN
            ee = (m_owner >= 0) && !eb && (m_stall == TO);
`else
            ee = 1'b0;
`endif
            checks++; if (grant !== eg || owner !== 2'((m_owner < 0) ? 0 : m_owner)) begin failures++; $display("FAIL rnd_grant c=%0d got=%b/%0d exp=%b/%0d", c, grant, owner, eg, m_owner); end
            checks++; if (out_valid !== ev || out_data !== ed) begin failures++; $display("FAIL rnd_port c=%0d got=%b/%h exp=%b/%h", c, out_valid, out_data, ev, ed); end
            checks++; if (ready !== er || err !== ee) begin failures++; $display("FAIL rnd_ready_err c=%0d got=%b/%b exp=%b/%b", c, ready, err, er, ee); end
            if (rst) begin
                m_owner = -1; m_ptr = 0; m_stall = 0;
            end else if (m_owner < 0) begin
                m_owner = scan(req, m_ptr, -1);
            end else if ((eb && last[m_owner]) || ee) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = scan(req, m_ptr, m_owner);
                m_stall = 0;
            end else begin
                m_stall = eb ? 0 : m_stall + 1;
            end
            cyc();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
